// File: rtl/reset_request_tracker_pkg.sv
// Shared types and helpers for the reset request tracker: one-hot state
// encodings and the counter sizing function.
package reset_request_tracker_pkg;

    typedef enum logic [3:0] {
        S_RT_IDLE   = 4'b0001,
        S_RT_SIGNAL = 4'b0010,
        S_RT_WAIT   = 4'b0100,
        S_RT_ACTIVE = 4'b1000
    } rt_state_e;

    // Bits needed to hold values 0..value-1, never less than 1.
    function automatic int clog2s(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/reset_request_tracker_if.sv
// Request, monitored stream and reset_controller handshake signals seen by
// the tracker. The tracker uses the slave view; its environment uses master.
interface reset_request_tracker_if;

    logic REQ_RST;
    logic REQ_GRACEFUL;
    logic VALID;
    logic READY;
    logic START_FLAG;
    logic END_FLAG;
    logic DONE_RST;
    logic RST_OUT;
    logic SIGNAL_RST;
    logic WAIT_RST;
    logic NEXT_CYC_RST;
    logic HOLD_START;
    logic BUSY;
    logic TIMEOUT_FLAG;

    modport master (
        output REQ_RST, REQ_GRACEFUL, VALID, READY, START_FLAG, END_FLAG,
        output DONE_RST, RST_OUT,
        input  SIGNAL_RST, WAIT_RST, NEXT_CYC_RST, HOLD_START, BUSY, TIMEOUT_FLAG
    );

    modport slave (
        input  REQ_RST, REQ_GRACEFUL, VALID, READY, START_FLAG, END_FLAG,
        input  DONE_RST, RST_OUT,
        output SIGNAL_RST, WAIT_RST, NEXT_CYC_RST, HOLD_START, BUSY, TIMEOUT_FLAG
    );

endinterface

// File: rtl/reset_request_tracker_counter.sv
// Free-running up counter with an active-high clear; only compiled when
// RESET_TIMEOUT_EN is defined, where it times the tracker's WAIT state.
`ifdef RESET_TIMEOUT_EN
module counter #(
    parameter int C_WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST_IN,
    input  logic               ENABLE,
    output logic [C_WIDTH-1:0] COUNT
);

    always_ff @(posedge CLK or posedge RST_IN) begin
        if (RST_IN) begin
            COUNT <= '0;
        end else if (ENABLE) begin
            COUNT <= COUNT + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/reset_request_tracker.sv
// Sequences software reset requests into reset_controller so graceful resets
// land between packets. Optional WAIT timeout: define RESET_TIMEOUT_EN.
module reset_request_tracker
    import reset_request_tracker_pkg::*;
#(
    parameter int C_TIMEOUT_CYCLES = 1024
) (
    input  logic                          CLK,
    input  logic                          RST_IN_N,
    reset_request_tracker_if.slave        bus
);

    rt_state_e state_q;
    rt_state_e state_d;
    logic      in_pkt_q;
    logic      graceful_q;
    logic      seen_q;
    logic      timeout_flag_q;
    logic      xfer;
    logic      end_beat;
    logic      in_wait;
    logic      req_accept;
    logic      timeout;
    logic      next_cyc;

    if (C_TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("C_TIMEOUT_CYCLES must be at least 1");
    end

    assign xfer       = bus.VALID & bus.READY;
    assign end_beat   = xfer & bus.END_FLAG;
    assign in_wait    = (state_q == S_RT_WAIT);
    assign req_accept = (state_q == S_RT_IDLE) & bus.REQ_RST;

`ifdef RESET_TIMEOUT_EN
    localparam int CNT_W = clog2s(C_TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_count;
    logic             wait_count_clr;

    // Held clear outside WAIT, so the count restarts from 0 on every entry.
    assign wait_count_clr = ~in_wait | ~RST_IN_N;

    counter #(
        .C_WIDTH (CNT_W)
    ) u_wait_counter (
        .CLK    (CLK),
        .RST_IN (wait_count_clr),
        .ENABLE (1'b1),
        .COUNT  (wait_count)
    );

    assign timeout = in_wait & (wait_count == CNT_W'(C_TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Combinational so an end beat in the current cycle already counts.
    assign next_cyc         = in_wait & (~in_pkt_q | end_beat | timeout);
    assign bus.NEXT_CYC_RST = next_cyc;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path through the case statement can infer a latch.
    always_comb begin
        state_d        = state_q;
        bus.SIGNAL_RST = 1'b0;
        bus.WAIT_RST   = 1'b0;
        bus.HOLD_START = 1'b0;
        bus.BUSY       = 1'b1;
        case (state_q)
            S_RT_IDLE: begin
                bus.BUSY = 1'b0;
                if (bus.REQ_RST) begin
                    state_d = S_RT_SIGNAL;
                end
            end
            S_RT_SIGNAL: begin
                bus.SIGNAL_RST = 1'b1;
                bus.WAIT_RST   = graceful_q;
                if (bus.DONE_RST) begin
                    state_d = graceful_q ? S_RT_WAIT : S_RT_ACTIVE;
                end
            end
            S_RT_WAIT: begin
                bus.HOLD_START = 1'b1;
                if (next_cyc) begin
                    state_d = S_RT_ACTIVE;
                end
            end
            S_RT_ACTIVE: begin
                bus.HOLD_START = 1'b1;
                if (seen_q & bus.DONE_RST) begin
                    state_d = S_RT_IDLE;
                end
            end
            default: begin
                bus.BUSY = 1'b0;
                state_d  = S_RT_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK or negedge RST_IN_N) begin
        if (!RST_IN_N) begin
            state_q <= S_RT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Packet tracking; the clear terms win over a start beat.
    always_ff @(posedge CLK or negedge RST_IN_N) begin
        if (!RST_IN_N) begin
            in_pkt_q <= 1'b0;
        end else if (end_beat | bus.RST_OUT) begin
            in_pkt_q <= 1'b0;
        end else if (xfer & bus.START_FLAG & ~bus.END_FLAG) begin
            in_pkt_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_IN_N) begin
        if (!RST_IN_N) begin
            graceful_q <= 1'b0;
        end else if (req_accept) begin
            graceful_q <= bus.REQ_GRACEFUL;
        end
    end

    // Remembers that the controller actually asserted its reset, so DONE_RST
    // seen before RST_OUT does not end the ACTIVE phase early.
    always_ff @(posedge CLK or negedge RST_IN_N) begin
        if (!RST_IN_N) begin
            seen_q <= 1'b0;
        end else if (state_q == S_RT_ACTIVE) begin
            if (seen_q & bus.DONE_RST) begin
                seen_q <= 1'b0;
            end else if (bus.RST_OUT) begin
                seen_q <= 1'b1;
            end
        end
    end

`ifdef RESET_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RST_IN_N) begin
        if (!RST_IN_N) begin
            timeout_flag_q <= 1'b0;
        end else if (req_accept) begin
            timeout_flag_q <= 1'b0;
        end else if (timeout) begin
            timeout_flag_q <= 1'b1;
        end
    end
`else
    assign timeout_flag_q = 1'b0;
`endif

    assign bus.TIMEOUT_FLAG = timeout_flag_q;

endmodule

// File: tb/tb_reset_request_tracker.sv
// Self-checking bench for reset_request_tracker: directed scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_reset_request_tracker;

    localparam int C_TMO = 16;
`ifdef RESET_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef enum int {P_IDLE, P_SIGNAL, P_WAIT, P_ACTIVE} phase_e;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_bad    = 0;

    phase_e m_phase;
    int     m_wait_cycles;
    bit     m_in_pkt, m_graceful, m_seen, m_tflag;
    logic   s_sig, s_wrst, s_next, s_hold, s_busy, s_tflag;

    always #5 clk = ~clk;

    reset_request_tracker_if bus ();

    reset_request_tracker #(
        .C_TIMEOUT_CYCLES (C_TMO)
    ) dut (
        .CLK      (clk),
        .RST_IN_N (rst_n),
        .bus      (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic bit m_timed_out();
        // The WAIT cycle numbered C_TMO (1-based) forces the boundary.
        return TMO_EN && (m_phase == P_WAIT) && ((m_wait_cycles + 1) == C_TMO);
    endfunction

    function automatic bit m_boundary();
        bit end_now;
        end_now = bus.VALID && bus.READY && bus.END_FLAG;
        return (m_phase == P_WAIT) && (!m_in_pkt || end_now || m_timed_out());
    endfunction

    task automatic model_reset();
        m_phase       = P_IDLE;
        m_wait_cycles = 0;
        m_in_pkt      = 0;
        m_graceful    = 0;
        m_seen        = 0;
        m_tflag       = 0;
    endtask

    task automatic model_step();
        bit xfer, bnd, tmo;
        xfer = bus.VALID && bus.READY;
        bnd  = m_boundary();
        tmo  = m_timed_out();
        case (m_phase)
            P_IDLE: if (bus.REQ_RST) begin
                m_graceful = bus.REQ_GRACEFUL;
                m_tflag    = 0;
                m_phase    = P_SIGNAL;
            end
            P_SIGNAL: if (bus.DONE_RST) begin
                m_phase       = m_graceful ? P_WAIT : P_ACTIVE;
                m_wait_cycles = 0;
            end
            P_WAIT: if (bnd) begin
                m_phase = P_ACTIVE;
                if (tmo) m_tflag = 1;
            end else begin
                m_wait_cycles++;
            end
            default: if (m_seen && bus.DONE_RST) begin
                m_phase = P_IDLE;
                m_seen  = 0;
            end else if (bus.RST_OUT) begin
                m_seen = 1;
            end
        endcase
        if ((xfer && bus.END_FLAG) || bus.RST_OUT) m_in_pkt = 0;
        else if (xfer && bus.START_FLAG) m_in_pkt = 1;
    endtask

    // One clock: compare all outputs mid-cycle, advance the model, then
    // return just after the rising edge so the caller can drive new inputs.
    task automatic tick();
        @(negedge clk);
        s_sig   = bus.SIGNAL_RST;
        s_wrst  = bus.WAIT_RST;
        s_next  = bus.NEXT_CYC_RST;
        s_hold  = bus.HOLD_START;
        s_busy  = bus.BUSY;
        s_tflag = bus.TIMEOUT_FLAG;
        check("signal_rst",   s_sig,   m_phase == P_SIGNAL);
        check("wait_rst",     s_wrst,  (m_phase == P_SIGNAL) && m_graceful);
        check("next_cyc_rst", s_next,  m_boundary());
        check("hold_start",   s_hold,  (m_phase == P_WAIT) || (m_phase == P_ACTIVE));
        check("busy",         s_busy,  m_phase != P_IDLE);
        check("timeout_flag", s_tflag, m_tflag);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_stream(input bit v, input bit r, input bit s, input bit e);
        bus.VALID      = v;
        bus.READY      = r;
        bus.START_FLAG = s;
        bus.END_FLAG   = e;
    endtask

    task automatic set_req(input bit req, input bit graceful);
        bus.REQ_RST      = req;
        bus.REQ_GRACEFUL = graceful;
    endtask

    task automatic quiet_inputs();
        set_stream(0, 0, 0, 0);
        set_req(0, 0);
        bus.DONE_RST = 1'b1;
        bus.RST_OUT  = 1'b0;
    endtask

    // Plays the controller side of a reset once the tracker is ACTIVE.
    task automatic finish_reset();
        set_stream(0, 0, 0, 0);
        set_req(0, 0);
        bus.RST_OUT  = 1'b1;
        bus.DONE_RST = 1'b0;
        repeat (2) tick();
        bus.RST_OUT  = 1'b0;
        bus.DONE_RST = 1'b1;
        repeat (2) tick();
    endtask

    task automatic open_packet();
        set_stream(1, 1, 1, 0);
        tick();
        set_stream(0, 0, 0, 0);
    endtask

    initial begin
        int sig_cycles;

        quiet_inputs();
        model_reset();
        rst_n = 1'b0;
        #1;
        check("rst_signal_rst", bus.SIGNAL_RST, 1'b0);
        check("rst_busy",       bus.BUSY,       1'b0);
        check("rst_hold_start", bus.HOLD_START, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Immediate reset.
        set_req(1, 0);
        tick();
        set_req(0, 0);
        tick();
        check("imm_sig_1",  s_sig,  1'b1);
        check("imm_wrst_0", s_wrst, 1'b0);
        tick();
        check("imm_sig_done", s_sig,  1'b0);
        check("imm_active",   s_hold, 1'b1);
        bus.RST_OUT  = 1'b1;
        bus.DONE_RST = 1'b0;
        repeat (10) tick();
        bus.RST_OUT  = 1'b0;
        bus.DONE_RST = 1'b1;
        tick();
        check("imm_busy_still", s_busy, 1'b1);
        tick();
        check("imm_busy_fall",  s_busy, 1'b0);

        // Graceful reset mid-packet: end beat comes 5 cycles after request.
        set_stream(1, 1, 1, 0);
        tick();
        set_stream(1, 1, 0, 0);
        repeat (3) tick();
        set_stream(0, 0, 0, 0);
        set_req(1, 1);
        tick();
        set_req(0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_next_low", s_next, 1'b0);
            if (i == 0) check("mid_signal_wrst", s_wrst, 1'b1);
            else        check("mid_hold",        s_hold, 1'b1);
        end
        set_stream(1, 1, 0, 1);
        tick();
        check("mid_next_end", s_next, 1'b1);
        tick();
        check("mid_next_after", s_next, 1'b0);
        finish_reset();

        // Graceful reset between packets.
        set_req(1, 1);
        tick();
        set_req(0, 0);
        tick();
        check("gap_wrst", s_wrst, 1'b1);
        tick();
        check("gap_next_first_wait", s_next, 1'b1);
        tick();
        finish_reset();

        // Single-beat packet leaves no packet open.
        set_stream(1, 1, 1, 1);
        tick();
        set_stream(0, 0, 0, 0);
        set_req(1, 1);
        tick();
        set_req(0, 0);
        repeat (2) tick();
        check("single_beat_next", s_next, 1'b1);
        tick();
        finish_reset();

        if (TMO_EN) begin
            // Packet never ends: WAIT cycle 16 forces the boundary.
            open_packet();
            set_req(1, 1);
            tick();
            set_req(0, 0);
            tick();
            for (int k = 1; k <= C_TMO; k++) begin
                tick();
                check("tmo_next", s_next, k == C_TMO);
            end
            tick();
            check("tmo_flag_set", s_tflag, 1'b1);
            finish_reset();
            tick();
            check("tmo_flag_hold", s_tflag, 1'b1);
            set_req(1, 0);
            tick();
            set_req(0, 0);
            tick();
            check("tmo_flag_clear", s_tflag, 1'b0);
            tick();
            finish_reset();
        end

        // Controller busy for 4 cycles, then a request dropped in WAIT.
        open_packet();
        bus.DONE_RST = 1'b0;
        set_req(1, 1);
        tick();
        set_req(0, 0);
        sig_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            bus.DONE_RST = (i == 4);
            tick();
            sig_cycles += int'(s_sig);
        end
        check("busy_sig_cycles", sig_cycles, 5);
        set_req(1, 0);
        tick();
        set_req(0, 0);
        tick();
        check("drop_no_signal", s_sig,  1'b0);
        check("drop_still_wait", s_hold, 1'b1);
        check("drop_no_next",   s_next, 1'b0);
        set_stream(1, 1, 0, 1);
        tick();
        check("drop_end_next", s_next, 1'b1);
        tick();
        finish_reset();

        // Asynchronous reset while waiting for a boundary.
        open_packet();
        set_req(1, 1);
        tick();
        set_req(0, 0);
        repeat (2) tick();
        check("async_pre_hold", s_hold, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_signal_rst",   bus.SIGNAL_RST,   1'b0);
        check("async_wait_rst",     bus.WAIT_RST,     1'b0);
        check("async_next_cyc_rst", bus.NEXT_CYC_RST, 1'b0);
        check("async_hold_start",   bus.HOLD_START,   1'b0);
        check("async_busy",         bus.BUSY,         1'b0);
        check("async_timeout_flag", bus.TIMEOUT_FLAG, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        quiet_inputs();
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            set_stream($urandom_range(0, 1), $urandom_range(0, 1),
                       $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            set_req($urandom_range(0, 15) == 0, $urandom_range(0, 1));
            bus.DONE_RST = $urandom_range(0, 3) != 0;
            bus.RST_OUT  = $urandom_range(0, 7) == 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/reset_request_tracker.md
# reset_request_tracker

Upstream sequencer for `reset_controller`.
- Accepts one-cycle software reset requests and tracks packet boundaries on the monitored valid/ready stream.
- Drives `SIGNAL_RST`, `WAIT_RST` and `NEXT_CYC_RST` so that graceful resets land exactly between packets.
- Holds off new packet starts while a reset is pending or active.
- Follows the controller's `DONE_RST` and `RST_OUT` feedback until the reset completes.

## Interface
Parameters:
- C_TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before a boundary is forced (used only with RESET_TIMEOUT_EN)

Ports:
- CLK  in  1  clock
- RST_IN_N  in  1  reset; asynchronous, active-low
- REQ_RST  in  1  reset request pulse
- REQ_GRACEFUL  in  1  sampled with REQ_RST; 1 = wait for a packet boundary
- VALID  in  1  monitored stream valid
- READY  in  1  monitored stream ready
- START_FLAG  in  1  beat is the first beat of a packet
- END_FLAG  in  1  beat is the last beat of a packet
- DONE_RST  in  1  from controller: controller is idle
- RST_OUT  in  1  from controller: reset is active
- SIGNAL_RST  out  1  to controller
- WAIT_RST  out  1  to controller
- NEXT_CYC_RST  out  1  to controller: boundary, reset may start next cycle
- HOLD_START  out  1  upstream must not transfer a START_FLAG beat while this is high
- BUSY  out  1  state != IDLE
- TIMEOUT_FLAG  out  1  sticky: the last graceful reset was forced by timeout

## Operation
- Xfer = VALID & READY.
- rInPkt:
  - Set on Xfer & START_FLAG & ~END_FLAG.
  - Cleared on Xfer & END_FLAG, and on any cycle with RST_OUT=1.
  - Clear has priority over set.
- rGraceful is latched from REQ_GRACEFUL when a request is accepted.

One-hot state machine:
- IDLE:
  - REQ_RST=1: latch rGraceful, clear TIMEOUT_FLAG, go to SIGNAL.
- SIGNAL:
  - SIGNAL_RST=1; WAIT_RST=rGraceful.
  - If DONE_RST=1, go to WAIT when rGraceful=1, else go to ACTIVE.
  - If DONE_RST=0 (controller busy), stay in SIGNAL.
- WAIT:
  - HOLD_START=1.
  - NEXT_CYC_RST = ~rInPkt | (Xfer & END_FLAG) | timeout.
  - When NEXT_CYC_RST=1, go to ACTIVE.
- ACTIVE:
  - HOLD_START=1.
  - rSeen is set when RST_OUT=1.
  - Go to IDLE when rSeen & DONE_RST; clear rSeen on that transition.

Other rules:
- REQ_RST outside IDLE is dropped; it causes no state change.
- RST_OUT asserted while in IDLE (hard reset through the controller) clears rInPkt only; the state stays IDLE.
- The `default` case returns the state machine to IDLE.

## Timing
- Values while RST_IN_N=0: state IDLE, rInPkt=0, rSeen=0, counter=0, and every output 0.
- SIGNAL_RST, WAIT_RST, HOLD_START and BUSY are decoded from registered state, with no combinational input path.
- NEXT_CYC_RST is combinational from state, rInPkt, Xfer and END_FLAG, so the same-cycle end beat qualifies.
- Latency from REQ_RST to SIGNAL_RST: 1 cycle.
- SIGNAL_RST lasts 1 cycle when the controller is idle.
- Graceful reset with no packet open: NEXT_CYC_RST is asserted on the first WAIT cycle.
- The timeout counter runs only in WAIT and clears on WAIT entry and exit.
- Simultaneous Xfer & START_FLAG & END_FLAG (single-beat packet) leaves rInPkt at 0.

## Configuration
- RESET_TIMEOUT_EN defined:
  - The WAIT counter is instantiated.
  - When the count equals C_TIMEOUT_CYCLES-1, NEXT_CYC_RST is forced to 1 and TIMEOUT_FLAG is set.
- RESET_TIMEOUT_EN undefined:
  - No counter is built.
  - The timeout term is constant 0 and TIMEOUT_FLAG is tied to 0.
  - WAIT waits indefinitely for a boundary.

## Structure
- Shared package holds:
  - State encodings S_RT_IDLE/SIGNAL/WAIT/ACTIVE (4-bit one-hot).
  - The `clog2s` helper used to size the counter to clog2s(C_TIMEOUT_CYCLES+1) bits.
- One sub-module: the existing `counter`, used as the WAIT timeout counter. It is instantiated only under RESET_TIMEOUT_EN, with ENABLE tied to 1 and RST_IN driven by (~inWait | ~RST_IN_N).

## Test plan
- Immediate reset:
  - Stimulus: DONE_RST=1; pulse REQ_RST with REQ_GRACEFUL=0.
  - Required response: SIGNAL_RST=1 and WAIT_RST=0 for exactly 1 cycle; then ACTIVE; after RST_OUT 10 cycles then DONE_RST, BUSY falls 1 cycle later.
- Graceful reset mid-packet:
  - Stimulus: START beat, 3 middle beats, request, then END beat 5 cycles later.
  - Required response: NEXT_CYC_RST=1 only in the END cycle; HOLD_START=1 from WAIT entry.
- Graceful reset between packets:
  - Stimulus: rInPkt=0; pulse REQ_RST with REQ_GRACEFUL=1.
  - Required response: NEXT_CYC_RST on the first WAIT cycle.
- Timeout (RESET_TIMEOUT_EN, C_TIMEOUT_CYCLES=16):
  - Stimulus: packet never ends.
  - Required response: NEXT_CYC_RST on WAIT cycle 16; TIMEOUT_FLAG=1, holding until the next accepted request.
- Controller busy and dropped requests:
  - Stimulus: DONE_RST=0 for 4 cycles; second REQ_RST pulse issued while in WAIT.
  - Required response: SIGNAL_RST held 5 cycles; the second REQ_RST is ignored.
- Asynchronous reset mid-WAIT:
  - Stimulus: drop RST_IN_N while in WAIT.
  - Required response: all outputs 0 immediately, without waiting for a CLK edge.
